// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- Y86-64 pipeline fetch stage
//
// Owns the F pipeline register (predicted PC). Selects the fetch address
// f_pc from the M-stage mispredict path, the W-stage ret path or the
// prediction. Decodes the instruction bytes returned by instruction memory,
// computes valP, the next predicted PC and a status code, and latches the
// results into the D pipeline register under stall/bubble control.
//
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_count / bubble_count.
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   F_stall              hold F_predPC
//   D_stall, D_bubble    hold / bubble the D register (stall has priority)
//   M_icode,M_Cnd,M_valA mispredicted-branch redirect
//   W_icode, W_valM      ret redirect
//   imem_error, Byte0,   instruction memory response at f_pc
//   Byte19
//   f_pc                 combinational fetch address to instruction memory
//   D_*                  D pipeline register outputs
//   fetch_count,         (FETCH_PERF_CNT_EN only) real loads / bubble loads
//   bubble_count
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic        imem_error,
    input  logic [7:0]  Byte0,
    input  logic [71:0] Byte19,
    output logic [63:0] f_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        stat: S_AOK, icode: I_NOP, ifun: 4'h0, ra: R_NONE, rb: R_NONE,
        valc: 64'd0, valp: 64'd0
    };

    logic [63:0] pred_pc_q;
    d_reg_t      d_q;
    d_reg_t      d_nxt;

    logic        need_regids;
    logic        need_valc;
    logic        instr_valid;
    logic [63:0] valc_reg;   // constant after a register byte
    logic [63:0] valc_noreg; // constant directly after Byte0
    logic [63:0] f_pred_pc;

    // Fetch address: mispredicted branch beats ret, both beat prediction.
    always_comb begin
        if (M_icode == I_JXX && !M_Cnd)
            f_pc = M_valA;
        else if (W_icode == I_RET)
            f_pc = W_valM;
        else
            f_pc = pred_pc_q;
    end

    // Byte19 is big-end-first in the bus, the constant is little-endian in
    // memory, so reverse the byte order for each possible constant position.
    always_comb begin
        valc_reg   = '0;
        valc_noreg = '0;
        for (int i = 0; i < 8; i++) begin
            valc_reg[8*i +: 8]   = Byte19[63-8*i -: 8];
            valc_noreg[8*i +: 8] = Byte19[71-8*i -: 8];
        end
    end

    always_comb begin
        d_nxt = D_BUBBLE;

        if (imem_error) begin
            d_nxt.icode = I_NOP;
            d_nxt.ifun  = 4'h0;
        end else begin
            d_nxt.icode = Byte0[7:4];
            d_nxt.ifun  = Byte0[3:0];
        end

        instr_valid = (d_nxt.icode <= 4'hB);

        case (d_nxt.icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            default:                                  need_regids = 1'b0;
        endcase

        case (d_nxt.icode)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
            default:                      need_valc = 1'b0;
        endcase

        if (need_regids) begin
            d_nxt.ra = Byte19[71:68];
            d_nxt.rb = Byte19[67:64];
        end else begin
            d_nxt.ra = R_NONE;
            d_nxt.rb = R_NONE;
        end

        if (!need_valc)
            d_nxt.valc = 64'd0;
        else if (need_regids)
            d_nxt.valc = valc_reg;
        else
            d_nxt.valc = valc_noreg;

        // Wraps modulo 2^64 by construction.
        d_nxt.valp = f_pc + 64'd1 + 64'(need_regids)
                   + (need_valc ? 64'd8 : 64'd0);

        if (imem_error)
            d_nxt.stat = S_ADR;
        else if (!instr_valid)
            d_nxt.stat = S_INS;
        else if (d_nxt.icode == I_HALT)
            d_nxt.stat = S_HLT;
        else
            d_nxt.stat = S_AOK;

        // Jumps are predicted taken; call always goes to its target.
        if (d_nxt.icode == I_JXX || d_nxt.icode == I_CALL)
            f_pred_pc = d_nxt.valc;
        else
            f_pred_pc = d_nxt.valp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pred_pc_q <= RESET_PC;
        else if (!F_stall)
            pred_pc_q <= f_pred_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            d_q <= D_BUBBLE;
        else if (D_stall)
            d_q <= d_q;
        else if (D_bubble)
            d_q <= D_BUBBLE;
        else
            d_q <= d_nxt;
    end

    assign D_stat  = d_q.stat;
    assign D_icode = d_q.icode;
    assign D_ifun  = d_q.ifun;
    assign D_rA    = d_q.ra;
    assign D_rB    = d_q.rb;
    assign D_valC  = d_q.valc;
    assign D_valP  = d_q.valp;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else if (!D_stall) begin
            if (D_bubble)
                bubble_count <= bubble_count + 32'd1;
            else
                fetch_count  <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Y86-64 pipeline fetch stage that sits directly upstream of the instruction memory.
- Owns the F pipeline register (predicted PC) and selects f_pc, which it drives to the instruction memory.
- Splits the returned Byte0/Byte19 into instruction fields, computes valP and the predicted next PC, and assigns a status code.
- Latches the results into the D pipeline register under stall/bubble control from the pipeline control unit.

Parameters:
RESET_PC, 64'd0, value loaded into F_predPC on reset.

Ports:
clk  input  1  system clock, all registers rising-edge.
reset  input  1  asynchronous, active-high reset.
F_stall  input  1  hold F_predPC.
D_stall  input  1  hold D register.
D_bubble  input  1  load nop bubble into D register.
M_icode  input  4  icode in M stage.
M_Cnd  input  1  branch condition in M stage.
M_valA  input  64  fall-through PC of a mispredicted jXX.
W_icode  input  4  icode in W stage.
W_valM  input  64  return address popped by ret.
imem_error  input  1  instruction memory address error.
Byte0  input  8  byte at f_pc: {icode[7:4], ifun[3:0]}.
Byte19  input  72  bytes f_pc+1..f_pc+9; byte f_pc+1 in [71:64], byte f_pc+9 in [7:0].
f_pc  output  64  combinational fetch address to instruction memory.
D_stat  output  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
D_icode  output  4  registered icode.
D_ifun  output  4  registered ifun.
D_rA  output  4  registered rA.
D_rB  output  4  registered rB.
D_valC  output  64  registered constant word.
D_valP  output  64  registered incremented PC.

Behaviour:
- Reset (async, active-high): F_predPC <= RESET_PC. D register is loaded with the bubble value: stat 1, icode 1, ifun 0, rA F, rB F, valC 0, valP 0.
- f_pc selection is combinational, first match wins:
  - M_icode==7 and M_Cnd==0: f_pc = M_valA.
  - Else W_icode==9: f_pc = W_valM.
  - Else: f_pc = F_predPC.
- Field decode:
  - imem_error=1 forces icode 1, ifun 0.
  - Otherwise icode = Byte0[7:4], ifun = Byte0[3:0].
- Instruction classes:
  - instr_valid: icode <= 4'hB.
  - need_regids: icode in {2,3,4,5,6,A,B}.
  - need_valC: icode in {3,4,5,7,8}.
- Register fields: if need_regids, rA = Byte19[71:68] and rB = Byte19[67:64]. Otherwise rA = rB = 4'hF.
- valC is little-endian:
  - With regids: bytes f_pc+2..f_pc+9, LSB = Byte19[63:56], MSB = Byte19[7:0].
  - Without regids: bytes f_pc+1..f_pc+8, LSB = Byte19[71:64], MSB = Byte19[15:8].
  - 0 when need_valC=0.
- valP = f_pc + 1 + need_regids + 8*need_valC, modulo 2^64 (wraps, no error).
- f_predPC = valC for icode 7 or 8, else valP.
- Status priority:
  - imem_error: 3 (ADR).
  - !instr_valid: 4 (INS).
  - icode 0: 2 (HLT).
  - Otherwise: 1 (AOK).
- F register: on each edge, if !F_stall then F_predPC <= f_predPC, else hold.
- D register, evaluated on each edge in priority order:
  - D_stall=1: hold; D_bubble is ignored.
  - D_bubble=1: load the bubble value.
  - Otherwise: load stat/icode/ifun/rA/rB/valC/valP.
- Latency: fields at f_pc appear on D_* one cycle later. f_pc follows the M/W inputs in the same cycle.
- The block never stalls itself. Halting the pipeline on a non-AOK status is the control unit's responsibility.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_count[31:0]: increments when the D register loads a real instruction (not stalled, not bubbled).
  - bubble_count[31:0]: increments when a bubble is loaded.
  - Both reset to 0 and wrap at 2^32.
- When undefined, neither port nor counter logic exists and the block behaves identically otherwise.

Test Plan:
1. RESET_PC=112, release reset, Byte0=0x30, Byte19=0xF8_08_00..00 -> f_pc=112; next edge: D_icode=3, D_rA=F, D_rB=8, D_valC=8, D_valP=122, D_stat=1; f_pc=122.
2. f_pc=143, Byte0=0x70, Byte19[71:64]=0x91, rest 0 -> D_valC=0x91, D_valP=152, D_rA=D_rB=F; next f_pc=0x91.
3. M_icode=7, M_Cnd=0, M_valA=0x200, with W_icode=9 and W_valM=0x300 in the same cycle -> f_pc=0x200. Drop the M condition -> f_pc=0x300.
4. imem_error=1 -> D_stat=3, D_icode=1. Byte0=0xC0 -> D_stat=4. Byte0=0x00 at f_pc=40 -> D_stat=2, D_valP=41.
5. F_stall=D_stall=D_bubble=1 for 2 cycles -> F_predPC and all D_* hold. D_stall=0 with D_bubble=1 -> D_icode=1, D_stat=1, D_valP=0, D_rA=F.
6. Assert reset mid-cycle between edges -> D_* take the bubble value and f_pc=RESET_PC immediately. With FETCH_PERF_CNT_EN defined, counters read 0, then count 3 fetches and 1 bubble correctly.
